// File: rtl/normal_cdf_if.sv
// Stream bundle for normal_cdf: z_in request side, p_out result side.
// pdf_out is present only when NCDF_PDF_EN is defined.
interface normal_cdf_if #(
  parameter int WIDTH = 32
);
  logic             valid_in;
  logic             ready_out;
  logic [WIDTH-1:0] z_in;
  logic             valid_out;
  logic             ready_in;
  logic [WIDTH-1:0] p_out;
`ifdef NCDF_PDF_EN
  logic [WIDTH-1:0] pdf_out;

  modport master (output valid_in, z_in, ready_in, input ready_out, valid_out, p_out, pdf_out);
  modport slave  (input valid_in, z_in, ready_in, output ready_out, valid_out, p_out, pdf_out);
`else
  modport master (output valid_in, z_in, ready_in, input ready_out, valid_out, p_out);
  modport slave  (input valid_in, z_in, ready_in, output ready_out, valid_out, p_out);
`endif
endinterface

// File: rtl/normal_cdf.sv
// Standard-normal CDF p = Phi(z) by 32-segment linear interpolation, 4-stage pipeline.
// Define NCDF_PDF_EN to add pdf_out = phi(z). ROM contents assume QFRAC=16, ZMAX_LOG2=3, SEG_BITS=5.
module normal_cdf #(
  parameter int WIDTH     = 32,
  parameter int QINT      = 16,
  parameter int QFRAC     = 16,
  parameter int ZMAX_LOG2 = 3,
  parameter int SEG_BITS  = 5
) (
  input  logic        clk,
  input  logic        rst,
  normal_cdf_if.slave bus
);
  localparam int ZB  = QFRAC + ZMAX_LOG2;
  localparam int FW  = ZB - SEG_BITS;
  localparam int CW  = QFRAC + 1;
  localparam int CW1 = CW + 1;
  localparam logic [CW-1:0] ONE_C  = CW'(1) << QFRAC;
  localparam logic [CW:0]   ONE_S  = CW1'(1) << QFRAC;
  localparam logic [CW:0]   HALF_S = CW1'(1) << (QFRAC - 1);

  // Phi at segment starts k*0.25, scaled by 2**16; index 32 is the 1.0 end point.
  function automatic logic [CW-1:0] c0_rom(input int k);
    int v;
    case (k)
      0:  v = 32768;   1: v = 39237;   2: v = 45316;   3: v = 50684;
      4:  v = 55138;   5: v = 58612;   6: v = 61158;   7: v = 62911;
      8:  v = 64045;   9: v = 64735;  10: v = 65129;  11: v = 65341;
      12: v = 65448;  13: v = 65498;  14: v = 65521;  15: v = 65530;
      16: v = 65534;  17: v = 65535;
      default: v = 65536;
    endcase
    return CW'(v);
  endfunction

  function automatic logic [CW-1:0] interp(input logic [CW-1:0] d, input logic [FW-1:0] f);
    logic [CW+FW-1:0] prod;
    prod = d * f;
    return CW'(prod >> FW);
  endfunction

  function automatic logic [CW-1:0] clamp_q(input logic sat, input logic [CW:0] s);
    logic [CW:0] r;
    if (sat || s > ONE_S) r = ONE_S;
    else if (s < HALF_S)  r = HALF_S;
    else                  r = s;
    return CW'(r);
  endfunction

`ifdef NCDF_PDF_EN
  function automatic logic [CW-1:0] e0_rom(input int k);
    int v;
    case (k)
      0:  v = 26145;   1: v = 25341;   2: v = 23073;   3: v = 19735;
      4:  v = 15858;   5: v = 11970;   6: v = 8488;    7: v = 5654;
      8:  v = 3538;    9: v = 2080;   10: v = 1149;   11: v = 596;
      12: v = 290;    13: v = 133;    14: v = 57;     15: v = 23;
      16: v = 9;      17: v = 3;      18: v = 1;
      default: v = 0;
    endcase
    return CW'(v);
  endfunction

  function automatic logic signed [CW:0] interp_s(input logic signed [CW:0] d, input logic [FW-1:0] f);
    logic signed [CW+FW+1:0] prod;
    prod = d * $signed({1'b0, f});
    return CW1'(prod >>> FW);
  endfunction
`endif

  logic                    en;
  logic                    vld_p0, vld_p1, vld_p2, vld_out;
  logic                    sign_p0, sign_p1, sign_p2;
  logic                    sat_p0, sat_p1, sat_p2;
  logic [SEG_BITS-1:0]     idx_p0;
  logic [FW-1:0]           frac_p0, frac_p1;
  logic [CW-1:0]           c0_p1, d_p1, c0_p2, m_p2, q;
  logic [WIDTH-1:0]        p_reg, p_next;
  logic signed [WIDTH-1:0] z_s;
  logic [WIDTH-1:0]        a;
  logic                    sat_c;

  assign en            = bus.ready_in | ~vld_out;
  assign bus.ready_out = en;
  assign bus.valid_out = vld_out;
  assign bus.p_out     = p_reg;

  // Stage 1 input: fold to |z|; -2**(WIDTH-1) has no positive twin and lands in sat
  assign z_s   = bus.z_in;
  assign a     = z_s[WIDTH-1] ? -z_s : z_s;
  assign sat_c = a[WIDTH-1] | (|a[QINT+QFRAC-1:ZB]);

  // Stage 4 input: reflect the upper-half result for negative z
  assign q      = clamp_q(sat_p2, {1'b0, c0_p2} + {1'b0, m_p2});
  assign p_next = WIDTH'(sign_p2 ? ONE_C - q : q);

`ifdef NCDF_PDF_EN
  logic [CW-1:0]        e0_p1, e0_p2;
  logic signed [CW:0]   de_p1, me_p2;
  logic signed [CW:0]   pdf_sum;
  logic [WIDTH-1:0]     pdf_reg, pdf_next;

  assign pdf_sum     = $signed({1'b0, e0_p2}) + me_p2;
  assign pdf_next    = sat_p2 ? '0 : WIDTH'($unsigned(pdf_sum));
  assign bus.pdf_out = pdf_reg;
`endif

  always_ff @(posedge clk) begin
    if (en) begin
      // S1 -> S2: segment index and in-segment offset
      sign_p0 <= z_s[WIDTH-1];
      sat_p0  <= sat_c;
      idx_p0  <= a[ZB-1 -: SEG_BITS];
      frac_p0 <= a[FW-1:0];
      // S2 -> S3: ROM base and slope
      sign_p1 <= sign_p0;
      sat_p1  <= sat_p0;
      frac_p1 <= frac_p0;
      c0_p1   <= c0_rom(int'(idx_p0));
      d_p1    <= c0_rom(int'(idx_p0) + 1) - c0_rom(int'(idx_p0));
      // S3 -> S4: interpolation term
      sign_p2 <= sign_p1;
      sat_p2  <= sat_p1;
      c0_p2   <= c0_p1;
      m_p2    <= interp(d_p1, frac_p1);
`ifdef NCDF_PDF_EN
      e0_p1   <= e0_rom(int'(idx_p0));
      de_p1   <= $signed({1'b0, e0_rom(int'(idx_p0) + 1)}) - $signed({1'b0, e0_rom(int'(idx_p0))});
      e0_p2   <= e0_p1;
      me_p2   <= interp_s(de_p1, frac_p1);
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      vld_p0  <= 1'b0;
      vld_p1  <= 1'b0;
      vld_p2  <= 1'b0;
      vld_out <= 1'b0;
      p_reg   <= '0;
`ifdef NCDF_PDF_EN
      pdf_reg <= '0;
`endif
    end else if (en) begin
      vld_p0  <= bus.valid_in;
      vld_p1  <= vld_p0;
      vld_p2  <= vld_p1;
      vld_out <= vld_p2;
      if (vld_p2) begin
        p_reg   <= p_next;
`ifdef NCDF_PDF_EN
        pdf_reg <= pdf_next;
`endif
      end
    end
  end
endmodule
